// File: rtl/imem_loader.sv
// imem_loader: assembles big-endian byte pairs into 16-bit instruction words
// and writes them into a two-bank (2 x 16 words) instruction memory. An
// optional trailing checksum byte closes the session.
module imem_loader #(
   parameter bit CHECKSUM_EN = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic        abort_i,
   input  logic [7:0]  byte_in_i,
   input  logic        byte_valid_i,
   output logic        byte_ready_o,
   output logic [15:0] imem_input_o,
   output logic [3:0]  write_select_o,
   output logic        write_enable_low_o,
   output logic        write_enable_high_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        error_o,
   output logic [5:0]  word_count_o
);

   typedef enum logic [2:0] {IDLE, HI, LO, WR, CHK, FIN, ERR} state_e;

   state_e      state_q, state_d;
   logic [15:0] data_q, data_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [7:0]  acc_q, acc_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   logic ready, busy, accept, wr_fire;

   // Readiness is a pure function of state; abort only masks the effect.
   assign ready   = (state_q == HI) || (state_q == LO) || (state_q == CHK);
   assign busy    = ready || (state_q == WR);
   assign accept  = ready && byte_valid_i && !abort_i;
   assign wr_fire = (state_q == WR) && !abort_i;

   assign byte_ready_o        = ready;
   assign busy_o              = busy;
   assign imem_input_o        = data_q;
   assign write_select_o      = cnt_q[3:0];
   assign write_enable_low_o  = wr_fire && !cnt_q[4];
   assign write_enable_high_o = wr_fire &&  cnt_q[4];
   assign done_o              = done_q;
   assign error_o             = err_q;
   assign word_count_o        = cnt_q;

   // Next-state logic: abort while busy pre-empts every other transition.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      done_d  = done_q;
      err_d   = err_q;
      if (busy && abort_i) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE, FIN, ERR: begin
               if (start_i) begin
                  state_d = HI;
                  cnt_d   = 6'd0;
                  acc_d   = 8'd0;
                  done_d  = 1'b0;
                  err_d   = 1'b0;
               end
            end
            HI: begin
               if (accept) begin
                  data_d[15:8] = byte_in_i;
                  acc_d        = acc_q + byte_in_i;
                  state_d      = LO;
               end
            end
            LO: begin
               if (accept) begin
                  data_d[7:0] = byte_in_i;
                  acc_d       = acc_q + byte_in_i;
                  state_d     = WR;
               end
            end
            WR: begin
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'd31) begin
                  if (CHECKSUM_EN) begin
                     state_d = CHK;
                  end else begin
                     state_d = FIN;
                     done_d  = 1'b1;
                  end
               end else begin
                  state_d = HI;
               end
            end
            CHK: begin
               if (accept) begin
                  if (byte_in_i == acc_q) begin
                     state_d = FIN;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ERR;
                     err_d   = 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         data_q  <= 16'h0000;
         cnt_q   <= 6'd0;
         acc_q   <= 8'd0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a directed vector table for single-cycle behaviour,
// followed by hand-written full-load, checksum, stall, abort and reset runs.
// Two instances share the stimulus: u0 with checksum, u1 without.
module tb_imem_loader;

   logic        clk, rst_n, start, abort, bval;
   logic [7:0]  bin;
   logic        rdy0, wlo0, whi0, busy0, done0, err0;
   logic [15:0] data0;
   logic [3:0]  wsel0;
   logic [5:0]  cnt0;
   logic        rdy1, wlo1, whi1, busy1, done1, err1;
   logic [15:0] data1;
   logic [3:0]  wsel1;
   logic [5:0]  cnt1;

   int n_cmp = 0;
   int n_err = 0;

   imem_loader #(.CHECKSUM_EN(1'b1)) u0 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
      .byte_in_i(bin), .byte_valid_i(bval), .byte_ready_o(rdy0),
      .imem_input_o(data0), .write_select_o(wsel0),
      .write_enable_low_o(wlo0), .write_enable_high_o(whi0),
      .busy_o(busy0), .done_o(done0), .error_o(err0), .word_count_o(cnt0));

   imem_loader #(.CHECKSUM_EN(1'b0)) u1 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
      .byte_in_i(bin), .byte_valid_i(bval), .byte_ready_o(rdy1),
      .imem_input_o(data1), .write_select_o(wsel1),
      .write_enable_low_o(wlo1), .write_enable_high_o(whi1),
      .busy_o(busy1), .done_o(done1), .error_o(err1), .word_count_o(cnt1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst_n, st, ab;
      logic [7:0] b;
      logic       v;
      logic       rdy, wlo, whi;
      logic [3:0] wsel;
      logic [15:0] data;
      logic       busy, done, err;
      logic [5:0] cnt;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Drive inputs just after the falling edge, leave 1 ns to settle.
   task automatic step(input logic st, input logic ab, input logic [7:0] b, input logic v);
      @(negedge clk);
      start = st; abort = ab; bin = b; bval = v;
      #1;
   endtask

   // Full 32-word session: word k = {8'h00, k}; checksum byte appended.
   task automatic run_load(input logic [7:0] cks, input bit rnd);
      int idx = 0, w = 0, cyc = 0, last_wr = -10;
      logic [7:0] b;
      logic v;
      step(1'b1, 1'b0, 8'h00, 1'b0);
      while (idx < 65 && cyc < 2000) begin
         if (idx == 64) b = cks;
         else if (idx % 2 == 1) b = 8'(idx / 2);
         else b = 8'h00;
         v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         step(1'b0, 1'b0, b, v);
         if (cyc == 0) begin
            chk("start_clr_done", done0, 0);
            chk("start_clr_err", err0, 0);
            chk("start_clr_cnt", cnt0, 0);
         end
         if (wlo0 || whi0) begin
            chk("wr_data", data0, w);
            chk("wr_sel", wsel0, w % 16);
            chk("wr_bank", {wlo0, whi0}, (w < 16) ? 2'b10 : 2'b01);
            chk("wr_both_bytes", idx, 2 * w + 2);
            chk("wr_rdy_low", rdy0, 0);
            w++;
            last_wr = cyc;
         end
         if (cyc == last_wr + 1 && w == 32) begin
            chk("nochk_done", done1, 1);
            chk("nochk_fin_rdy", rdy1, 0);
         end
         if (v && rdy0) idx++;
         cyc++;
      end
      chk("load_bytes_consumed", idx, 65);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk("load_words", w, 32);
      chk("load_cnt", cnt0, 32);
      chk("load_done", done0, (cks == 8'hF0) ? 1 : 0);
      chk("load_err", err0, (cks == 8'hF0) ? 0 : 1);
      chk("load_busy", busy0, 0);
      chk("load_rdy", rdy0, 0);
      chk("nochk_fin_rdy_hold", rdy1, 0);
      chk("nochk_done_hold", done1, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; bin = 8'h00; bval = 1'b0;

      //          rst   st    ab    b      v     rdy   wlo   whi   wsel  data      busy  done  err   cnt
      tbl[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 6'd0};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 6'd0};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 6'd0};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'hAB, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 6'd0};
      tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'hAB, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 6'd0};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'hCD, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 16'hAB00, 1'b1, 1'b0, 1'b0, 6'd0};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 16'hABCD, 1'b1, 1'b0, 1'b0, 6'd0};
      tbl[7]  = '{1'b1, 1'b1, 1'b0, 8'h12, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 16'hABCD, 1'b1, 1'b0, 1'b0, 6'd1};
      tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'h34, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 16'h12CD, 1'b1, 1'b0, 1'b0, 6'd1};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'h34, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 16'h12CD, 1'b1, 1'b0, 1'b0, 6'd1};
      tbl[10] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 16'h1234, 1'b1, 1'b0, 1'b0, 6'd1};
      tbl[11] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 16'h1234, 1'b0, 1'b0, 1'b0, 6'd1};
      tbl[12] = '{1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 16'h1234, 1'b0, 1'b0, 1'b0, 6'd1};

      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         rst_n = tbl[i].rst_n; start = tbl[i].st; abort = tbl[i].ab;
         bin = tbl[i].b; bval = tbl[i].v;
         #1;
         chk($sformatf("v%0d.rdy", i),  rdy0,  tbl[i].rdy);
         chk($sformatf("v%0d.wlo", i),  wlo0,  tbl[i].wlo);
         chk($sformatf("v%0d.whi", i),  whi0,  tbl[i].whi);
         chk($sformatf("v%0d.wsel", i), wsel0, tbl[i].wsel);
         chk($sformatf("v%0d.data", i), data0, tbl[i].data);
         chk($sformatf("v%0d.busy", i), busy0, tbl[i].busy);
         chk($sformatf("v%0d.done", i), done0, tbl[i].done);
         chk($sformatf("v%0d.err", i),  err0,  tbl[i].err);
         chk($sformatf("v%0d.cnt", i),  cnt0,  tbl[i].cnt);
      end

      // Good checksum, bad checksum, then a stalling source.
      run_load(8'hF0, 1'b0);
      run_load(8'h00, 1'b0);
      run_load(8'hF0, 1'b1);

      // Abort in LO of word 5.
      step(1'b1, 1'b0, 8'h00, 1'b0);
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 1'b0, 8'h00, 1'b1);
         step(1'b0, 1'b0, 8'(k), 1'b1);
         step(1'b0, 1'b0, 8'h00, 1'b1);
      end
      step(1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b0, 1'b1, 8'h05, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      chk("abort_busy", busy0, 0);
      chk("abort_cnt", cnt0, 5);
      chk("abort_done", done0, 0);
      chk("abort_err", err0, 0);
      chk("abort_data", data0, 16'h0004);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b0, 8'h00, 1'b1);
         chk("abort_no_strobe", {wlo0, whi0}, 2'b00);
      end
      run_load(8'hF0, 1'b0);

      // Reset pulse during WR of word 20.
      step(1'b1, 1'b0, 8'h00, 1'b0);
      for (int k = 0; k < 20; k++) begin
         step(1'b0, 1'b0, 8'h00, 1'b1);
         step(1'b0, 1'b0, 8'(k), 1'b1);
         step(1'b0, 1'b0, 8'h00, 1'b1);
      end
      step(1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b0, 1'b0, 8'd20, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk("w20_whi", whi0, 1);
      chk("w20_sel", wsel0, 4);
      chk("w20_data", data0, 16'h0014);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_whi_async", whi0, 0);
      chk("rst_wlo", wlo0, 0);
      chk("rst_rdy", rdy0, 0);
      chk("rst_data", data0, 0);
      chk("rst_sel", wsel0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      chk("rst_err", err0, 0);
      chk("rst_cnt", cnt0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk("post_rst_start_busy", busy0, 1);
      chk("post_rst_start_rdy", rdy0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
